counter_seq_ctrl: RTL and testbench



---
 rtl/counter_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: pushbutton-driven sequencer for an external 4-bit counter.
// A press starts a run of LAPS laps, each counting 0..TERM. A later press
// pauses the run, and the press after that resumes it. led toggles at the end
// of every lap.
// Optional feature: define COUNTER_SEQ_CTRL_DEBOUNCE_EN to insert a
// DB_CYCLES-long stability filter between the synchronizer and edge detection.
module counter_seq_ctrl #(
  parameter logic [3:0]  TERM      = 4'd9,
  parameter int unsigned LAPS      = 3,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic [3:0] cnt_value,
  output logic       en,
  output logic       clr,
  output logic       led,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Lap index of the final lap; the lap counter never goes past it.
  localparam logic [3:0] LAP_LAST = 4'(LAPS - 1);

  logic   s1_r;
  logic   s2_r;
  logic   prev_r;
  logic   level_s;
  logic   press_s;

  state_t state_r;
  state_t state_nxt_s;
  logic [3:0] lap_r;
  logic [3:0] lap_nxt_s;
  logic   led_r;
  logic   led_nxt_s;
  logic   busy_r;
  logic   done_r;
  logic   en_s;
  logic   clr_s;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= key;
      s2_r <= s1_r;
    end
  end

`ifdef COUNTER_SEQ_CTRL_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic       db_level_r;
  logic [7:0] db_cnt_r;

  // Debounce: adopt s2 only after it has disagreed for DB_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_level_r <= 1'b0;
      db_cnt_r   <= 8'd0;
    end else if (s2_r != db_level_r) begin
      if (db_cnt_r == DB_LAST) begin
        db_level_r <= s2_r;
        db_cnt_r   <= 8'd0;
      end else begin
        db_level_r <= db_level_r;
        db_cnt_r   <= db_cnt_r + 8'd1;
      end
    end else begin
      db_level_r <= db_level_r;
      db_cnt_r   <= 8'd0;
    end
  end

  assign level_s = db_level_r;
`else
  assign level_s = s2_r;
`endif

  // Previous-level register for rising-edge (press) detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  // A press is the single cycle where the key level has just gone high.
  assign press_s = level_s & ~prev_r;

  // Sequencer state, lap count, lap indicator and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      lap_r   <= 4'd0;
      led_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      lap_r   <= lap_nxt_s;
      led_r   <= led_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Next-state and counter controls. The terminal cycle is handled before any
  // coincident press, so a lap always closes cleanly before a pause.
  always_comb begin
    state_nxt_s = state_r;
    lap_nxt_s   = lap_r;
    led_nxt_s   = led_r;
    en_s        = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (press_s) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        clr_s       = 1'b1;
        lap_nxt_s   = 4'd0;
        state_nxt_s = RUN;
      end
      RUN: begin
        if (cnt_value == TERM) begin
          clr_s     = 1'b1;
          led_nxt_s = ~led_r;
          if (lap_r >= LAP_LAST) begin
            lap_nxt_s   = 4'd0;
            state_nxt_s = DONE;
          end else if (press_s) begin
            lap_nxt_s   = lap_r + 4'd1;
            state_nxt_s = PAUSE;
          end else begin
            lap_nxt_s   = lap_r + 4'd1;
            state_nxt_s = RUN;
          end
        end else begin
          // Also covers an out-of-range count: keep counting until it wraps to TERM.
          en_s = 1'b1;
          if (press_s) begin
            state_nxt_s = PAUSE;
          end else begin
            state_nxt_s = RUN;
          end
        end
      end
      PAUSE: begin
        if (press_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = PAUSE;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        lap_nxt_s   = 4'd0;
      end
    endcase
  end

  assign en   = en_s;
  assign clr  = clr_s;
  assign led  = led_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Testbench for counter_seq_ctrl with a behavioural model of the external
// 4-bit counter. Each scenario pushes its expected per-cycle outputs
// {en,clr,led,busy,done,cnt_value} into a queue. The scenario then pops one
// entry at each falling edge and compares it with the DUT outputs.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key = 1'b0;
  logic       env_clr = 1'b1;
  logic [3:0] cnt_value;
  logic       en, clr, led, busy, done;
  logic [8:0] obs;
  logic [8:0] exp_v;
  logic [8:0] exp_q [$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.TERM(4'd9), .LAPS(3), .DB_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .key(key), .cnt_value(cnt_value),
    .en(en), .clr(clr), .led(led), .busy(busy), .done(done)
  );

  assign obs = {en, clr, led, busy, done, cnt_value};

  // External counter: synchronous, clr over en, wraps 15->0; untouched by rst.
  always @(posedge clk) begin
    if (env_clr) cnt_value <= 4'd0;
    else if (clr) cnt_value <= 4'd0;
    else if (en) cnt_value <= cnt_value + 4'd1;
  end

  function automatic logic [8:0] pk(input logic e, input logic c, input logic l,
                                    input logic b, input logic d, input logic [3:0] v);
    return {e, c, l, b, d, v};
  endfunction

  task automatic push_idle(input logic l, input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pk(1'b0, 1'b0, l, 1'b0, 1'b0, v));
  endtask

  task automatic push_clear(input logic l, input logic [3:0] v);
    exp_q.push_back(pk(1'b0, 1'b1, l, 1'b1, 1'b0, v));
  endtask

  task automatic push_run(input logic l, input int from, input int to);
    for (int v = from; v <= to; v++) exp_q.push_back(pk(1'b1, 1'b0, l, 1'b1, 1'b0, 4'(v)));
  endtask

  task automatic push_term(input logic l);
    exp_q.push_back(pk(1'b0, 1'b1, l, 1'b1, 1'b0, 4'd9));
  endtask

  task automatic push_lap(input logic l);
    push_run(l, 0, 8);
    push_term(l);
  endtask

  task automatic push_pause(input logic l, input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pk(1'b0, 1'b0, l, 1'b1, 1'b0, v));
  endtask

  task automatic push_done(input logic l);
    exp_q.push_back(pk(1'b0, 1'b0, l, 1'b1, 1'b1, 4'd0));
  endtask

  task automatic test_reset();
    exp_q.delete();
    push_idle(1'b0, 4'd0, 3);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL reset cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL reset cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
    end
    rst = 1'b1;
    env_clr = 1'b0;
  endtask

`ifdef COUNTER_SEQ_CTRL_DEBOUNCE_EN
  task automatic test_debounce();
    exp_q.delete();
    push_idle(1'b0, 4'd0, 42);
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL debounce_glitch cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL debounce_glitch cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
      key = ((i % 5) == 0) && (i <= 35);
    end
    push_idle(1'b0, 4'd0, 18);
    push_clear(1'b0, 4'd0);
    push_lap(1'b0); push_lap(1'b1); push_lap(1'b0);
    push_done(1'b1);
    push_idle(1'b1, 4'd0, 5);
    key = 1'b1;
    for (int i = 1; i <= 55; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL debounce_hold cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL debounce_hold cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
      if (i == 20) key = 1'b0;
    end
  endtask
`else
  task automatic test_full_run();
    exp_q.delete();
    push_idle(1'b0, 4'd0, 2);
    push_clear(1'b0, 4'd0);
    push_lap(1'b0); push_lap(1'b1); push_lap(1'b0);
    push_done(1'b1);
    push_idle(1'b1, 4'd0, 2);
    key = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL full_run cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL full_run cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
      if (i == 5) key = 1'b0;
    end
  endtask

  task automatic test_pause();
    exp_q.delete();
    push_idle(1'b1, 4'd0, 2);
    push_clear(1'b1, 4'd0);
    push_run(1'b1, 0, 4);
    push_pause(1'b1, 4'd5, 6);
    push_run(1'b1, 5, 8);
    push_term(1'b1);
    push_lap(1'b0); push_lap(1'b1);
    push_done(1'b0);
    push_idle(1'b0, 4'd0, 2);
    key = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL pause cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL pause cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
      if (i == 1 || i == 7 || i == 13) key = 1'b0;
      if (i == 6 || i == 12) key = 1'b1;
    end
  endtask

  task automatic test_coincident();
    exp_q.delete();
    push_idle(1'b0, 4'd0, 2);
    push_clear(1'b0, 4'd0);
    push_run(1'b0, 0, 8);
    push_term(1'b0);
    push_pause(1'b1, 4'd0, 5);
    push_lap(1'b1); push_lap(1'b0);
    push_done(1'b1);
    push_idle(1'b1, 4'd0, 4);
    key = 1'b1;
    for (int i = 1; i <= 43; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL coincident cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL coincident cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
      if (i == 1 || i == 12 || i == 17 || i == 37) key = 1'b0;
      if (i == 11 || i == 16 || i == 36) key = 1'b1;
    end
  endtask

  task automatic test_drop_done();
    exp_q.delete();
    push_idle(1'b1, 4'd0, 2);
    push_clear(1'b1, 4'd0);
    push_lap(1'b1); push_lap(1'b0); push_lap(1'b1);
    push_done(1'b0);
    push_idle(1'b0, 4'd0, 4);
    key = 1'b1;
    for (int i = 1; i <= 38; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL drop_done cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL drop_done cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
      if (i == 1 || i == 33) key = 1'b0;
      if (i == 32) key = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    push_idle(1'b0, 4'd0, 2);
    push_clear(1'b0, 4'd0);
    push_lap(1'b0);
    push_run(1'b1, 0, 6);
    push_idle(1'b0, 4'd7, 6);
    key = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL reset_mid cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL reset_mid cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
      if (i == 1) key = 1'b0;
      if (i == 20) rst = 1'b0;
      if (i == 21) rst = 1'b1;
    end
  endtask

  task automatic test_key_held();
    exp_q.delete();
    push_idle(1'b0, 4'd7, 4);
    push_clear(1'b0, 4'd7);
    push_lap(1'b0); push_lap(1'b1); push_lap(1'b0);
    push_done(1'b1);
    push_idle(1'b1, 4'd0, 9);
    key = 1'b1;
    rst = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL key_held cyc=%0d: no expectation left, got %b", i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          bad++; $display("FAIL key_held cyc=%0d: got {en,clr,led,busy,done,cnt}=%b expected %b", i, obs, exp_v);
        end
      end
      if (i == 2) rst = 1'b1;
    end
    key = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
`ifdef COUNTER_SEQ_CTRL_DEBOUNCE_EN
    test_debounce();
`else
    test_full_run();
    test_pause();
    test_coincident();
    test_drop_done();
    test_reset_mid();
    test_key_held();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
